// File: rtl/maxpool_fifo_ctrl.sv
// Sequencer for the 2x2/stride-2 maxpool FIFO array: even rows write, odd rows read back in lockstep.
// Optional MAXPOOL_CTRL_ERR_EN adds a sticky protocol-error flag on err.
module maxpool_fifo_ctrl #(
   parameter int unsigned SYSTOLIC_SIZE = 16,
   parameter int unsigned ROW_CNT_W     = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ROW_CNT_W-1:0] num_rows,
   input  logic                 valid_in,
   output logic                 fifo_wr_clr,
   output logic                 fifo_rd_clr,
   output logic                 fifo_wr_en,
   output logic                 fifo_rd_en,
   output logic                 pool_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int unsigned COL_W = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(SYSTOLIC_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_EVEN,
      S_ODD,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [COL_W-1:0]     col_cnt_q, col_cnt_d;
   logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
   logic [ROW_CNT_W-1:0] num_rows_q, num_rows_d;
   logic                 pool_valid_q;
   logic                 row_active;
   logic                 row_end;
   logic                 last_row;

   assign row_active = (state_q == S_EVEN) || (state_q == S_ODD);
   assign row_end    = row_active && valid_in && (col_cnt_q == COL_LAST);
   assign last_row   = (ROW_CNT_W'(row_cnt_q + 1'b1) == num_rows_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         col_cnt_q    <= '0;
         row_cnt_q    <= '0;
         num_rows_q   <= '0;
         pool_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_cnt_q    <= col_cnt_d;
         row_cnt_q    <= row_cnt_d;
         num_rows_q   <= num_rows_d;
         pool_valid_q <= fifo_rd_en;
      end
   end

   // Next state, counters and enables; enables follow valid_in in the same cycle.
   always_comb begin
      state_d     = state_q;
      col_cnt_d   = col_cnt_q;
      row_cnt_d   = row_cnt_q;
      num_rows_d  = num_rows_q;
      fifo_wr_clr = 1'b0;
      fifo_rd_clr = 1'b0;
      fifo_wr_en  = 1'b0;
      fifo_rd_en  = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d    = S_CLR;
               num_rows_d = num_rows;
               col_cnt_d  = '0;
               row_cnt_d  = '0;
            end
         end
         S_CLR: begin
            fifo_wr_clr = 1'b1;
            fifo_rd_clr = 1'b1;
            state_d     = (num_rows_q == '0) ? S_FLUSH : S_EVEN;
         end
         S_EVEN, S_ODD: begin
            fifo_wr_en = (state_q == S_EVEN) && valid_in;
            fifo_rd_en = (state_q == S_ODD) && valid_in;
            if (row_end) begin
               col_cnt_d = '0;
               row_cnt_d = ROW_CNT_W'(row_cnt_q + 1'b1);
               if (last_row)
                  state_d = S_FLUSH;
               else
                  state_d = (state_q == S_EVEN) ? S_ODD : S_EVEN;
            end else if (valid_in) begin
               col_cnt_d = COL_W'(col_cnt_q + 1'b1);
            end
         end
         S_FLUSH: state_d = S_DONE;
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pool_valid = pool_valid_q;

`ifdef MAXPOOL_CTRL_ERR_EN
   logic err_q;

   // Sticky: stray valid_in outside row states, or start while a tile is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if ((valid_in && !row_active) || (start && busy))
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_maxpool_fifo_ctrl.sv
// Directed self-checking bench for maxpool_fifo_ctrl (err checks follow MAXPOOL_CTRL_ERR_EN).
module tb_maxpool_fifo_ctrl;

`ifdef MAXPOOL_CTRL_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [8:0] num_rows;
   logic       valid_in;
   logic       fifo_wr_clr;
   logic       fifo_rd_clr;
   logic       fifo_wr_en;
   logic       fifo_rd_en;
   logic       pool_valid;
   logic       busy;
   logic       done;
   logic       err;

   int n_checks = 0;
   int n_fail   = 0;

   maxpool_fifo_ctrl #(
      .SYSTOLIC_SIZE(16),
      .ROW_CNT_W    (9)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_rows   (num_rows),
      .valid_in   (valid_in),
      .fifo_wr_clr(fifo_wr_clr),
      .fifo_rd_clr(fifo_rd_clr),
      .fifo_wr_en (fifo_wr_en),
      .fifo_rd_en (fifo_rd_en),
      .pool_valid (pool_valid),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] all_outs();
      return {fifo_wr_clr, fifo_rd_clr, fifo_wr_en, fifo_rd_en, pool_valid, busy, done, err};
   endfunction

   // One tile: start pulse, CLR, row traffic from an independent word-index model, FLUSH, DONE, IDLE.
   task automatic run_tile(input int rows, input bit gap, input int exp_wr, input int exp_rd);
      int   w, k, nwr, nrd, npv, total;
      logic v, e_wr, e_rd, prev_rd;
      total = rows * 16;
      w = 0; k = 0; nwr = 0; nrd = 0; npv = 0; prev_rd = 1'b0;

      start = 1'b1; num_rows = 9'(rows); valid_in = 1'b0; #1;
      chk("start_idle_busy", 32'(busy), 32'd0);
      next_cyc();
      start = 1'b0; #1;
      chk("clr_wr_clr", 32'(fifo_wr_clr), 32'd1);
      chk("clr_rd_clr", 32'(fifo_rd_clr), 32'd1);
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_no_en", 32'({fifo_wr_en, fifo_rd_en}), 32'd0);
      next_cyc();

      while (w < total) begin
         v = gap ? ((k % 2) == 0) : 1'b1;
         valid_in = v; #1;
         e_wr = v && (((w / 16) % 2) == 0);
         e_rd = v && (((w / 16) % 2) == 1);
         chk("row_wr_en", 32'(fifo_wr_en), 32'(e_wr));
         chk("row_rd_en", 32'(fifo_rd_en), 32'(e_rd));
         chk("row_pool_valid", 32'(pool_valid), 32'(prev_rd));
         chk("row_no_clr_done", 32'({fifo_wr_clr, fifo_rd_clr, done}), 32'd0);
         nwr += int'(fifo_wr_en);
         nrd += int'(fifo_rd_en);
         npv += int'(pool_valid);
         prev_rd = e_rd;
         if (v) w++;
         k++;
         next_cyc();
      end

      valid_in = 1'b0; #1;
      chk("flush_no_en", 32'({fifo_wr_en, fifo_rd_en, done}), 32'd0);
      chk("flush_pool_valid", 32'(pool_valid), 32'(prev_rd));
      chk("flush_busy", 32'(busy), 32'd1);
      npv += int'(pool_valid);
      next_cyc(); #1;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_pool_valid", 32'(pool_valid), 32'd0);
      next_cyc(); #1;
      chk("idle_after_done", 32'({busy, done}), 32'd0);
      chk("tile_wr_count", 32'(nwr), 32'(exp_wr));
      chk("tile_rd_count", 32'(nrd), 32'(exp_rd));
      chk("tile_pv_count", 32'(npv), 32'(exp_rd));
      chk("tile_err", 32'(err), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; valid_in = 1'b0; start = 1'b0; #1;
      chk("reset_outs", 32'(all_outs()), 32'd0);
      next_cyc();
      rst_n = 1'b1; #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; valid_in = 1'b0; num_rows = '0;
      #1;
      chk("por_outs", 32'(all_outs()), 32'd0);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; #1;
      chk("por_idle", 32'(all_outs()), 32'd0);
      next_cyc();

      // Basic pair, gapped rows, odd row count (followed by a fresh tile), empty tile.
      run_tile(2, 1'b0, 16, 16);
      run_tile(4, 1'b1, 32, 32);
      run_tile(3, 1'b0, 32, 16);
      run_tile(2, 1'b0, 16, 16);
      run_tile(0, 1'b0, 0, 0);

      // Async reset in the middle of an odd row with a read in flight.
      start = 1'b1; num_rows = 9'd2; #1;
      next_cyc();
      start = 1'b0;
      next_cyc();
      valid_in = 1'b1;
      repeat (19) next_cyc();
      #1;
      chk("mid_rd_en", 32'(fifo_rd_en), 32'd1);
      chk("mid_pool_valid", 32'(pool_valid), 32'd1);
      rst_n = 1'b0; #1;
      chk("mid_reset_outs", 32'(all_outs()), 32'd0);
      next_cyc();
      valid_in = 1'b0; rst_n = 1'b1; #1;
      chk("post_reset_idle", 32'(all_outs()), 32'd0);
      next_cyc(); #1;
      chk("post_reset_stay", 32'({busy, fifo_wr_clr}), 32'd0);

      // valid_in while idle: no activity, err only when the check is built in.
      valid_in = 1'b1; #1;
      chk("idle_valid_no_en", 32'({fifo_wr_en, fifo_rd_en, busy}), 32'd0);
      chk("idle_valid_err_pre", 32'(err), 32'd0);
      next_cyc();
      valid_in = 1'b0; #1;
      chk("idle_valid_err", 32'(err), 32'(ERR_EN));
      next_cyc(); #1;
      chk("idle_valid_err_hold", 32'(err), 32'(ERR_EN));
      chk("idle_valid_busy", 32'(busy), 32'd0);
      do_reset();
      chk("err_cleared", 32'(err), 32'd0);

      // start while busy is ignored.
      start = 1'b1; num_rows = 9'd0; #1;
      next_cyc();
      num_rows = 9'd5; #1;
      chk("rs_clr", 32'(fifo_wr_clr), 32'd1);
      next_cyc();
      start = 1'b0; #1;
      chk("rs_flush_no_clr", 32'({fifo_wr_clr, fifo_rd_clr, done}), 32'd0);
      chk("rs_flush_busy", 32'(busy), 32'd1);
      chk("rs_err", 32'(err), 32'(ERR_EN));
      next_cyc(); #1;
      chk("rs_done", 32'(done), 32'd1);
      next_cyc(); #1;
      chk("rs_idle", 32'({busy, done}), 32'd0);
      next_cyc(); #1;
      chk("rs_no_restart", 32'({busy, fifo_wr_clr}), 32'd0);
      chk("rs_err_hold", 32'(err), 32'(ERR_EN));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
